// File: rtl/am2940_pkg.sv
// Shared definitions for the Am2940 DMA sequencer: instruction codes and FSM states.
package am2940_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INSTR_W = 3;

    localparam logic [INSTR_W-1:0] INS_WR_CTRL = 3'b000;
    localparam logic [INSTR_W-1:0] INS_RD_CTRL = 3'b001;
    localparam logic [INSTR_W-1:0] INS_RD_WCNT = 3'b010;
    localparam logic [INSTR_W-1:0] INS_RD_ADDR = 3'b011;
    localparam logic [INSTR_W-1:0] INS_REINIT  = 3'b100;
    localparam logic [INSTR_W-1:0] INS_LD_ADDR = 3'b101;
    localparam logic [INSTR_W-1:0] INS_LD_WCNT = 3'b110;
    localparam logic [INSTR_W-1:0] INS_ENABLE  = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CTRL,
        ST_LD_ADDR,
        ST_LD_WCNT,
        ST_ENABLE,
        ST_REQ,
        ST_STEP,
        ST_CHECK,
        ST_FINISH,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/am2940_seq.sv
// DMA block sequencer: programs an Am2940 address generator, then steps it once
// per acknowledged memory transfer until the word counter reports done.
module am2940_seq
    import am2940_pkg::*;
#(
    parameter int unsigned         ACK_TIMEOUT = 16,
    parameter logic [INSTR_W-1:0]  IDLE_INSTR  = 3'b001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DATA_W-1:0]  ctrl_word,
    input  logic [DATA_W-1:0]  base_addr,
    input  logic [DATA_W-1:0]  word_cnt,
    output logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  datain,
    output logic               cina,
    output logic               cinw,
    input  logic [DATA_W-1:0]  address,
    input  logic               done,
    output logic               mem_req,
    output logic [DATA_W-1:0]  mem_addr,
    input  logic               mem_ack,
    output logic               busy,
    output logic               blk_done,
    output logic               err,
    output logic [DATA_W-1:0]  xfer_cnt
);

    localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t             state, state_nxt;
    logic [TMO_W-1:0]   tmo, tmo_nxt;
    logic [DATA_W-1:0]  base_q, cnt_q;
    logic [DATA_W-1:0]  xfer_nxt;
    logic               capture;

    logic [INSTR_W-1:0] instr_nxt;
    logic [DATA_W-1:0]  datain_nxt;
    logic               step_nxt;
    logic               req_nxt;

    // Next-state, counters and the output values that go with the next state.
    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo;
        xfer_nxt   = xfer_cnt;
        capture    = 1'b0;
        instr_nxt  = IDLE_INSTR;
        datain_nxt = '0;
        step_nxt   = 1'b0;
        req_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    xfer_nxt  = '0;
                    state_nxt = (word_cnt == DATA_W'(0)) ? ST_FINISH : ST_WR_CTRL;
                end
            end
            ST_WR_CTRL: state_nxt = ST_LD_ADDR;
            ST_LD_ADDR: state_nxt = ST_LD_WCNT;
            ST_LD_WCNT: state_nxt = ST_ENABLE;
            ST_ENABLE: begin
                state_nxt = ST_REQ;
                tmo_nxt   = '0;
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt = ST_STEP;
                end else if (tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = ST_ERROR;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            ST_STEP: begin
                // The Am2940 has already been stepped, so the transfer counts even under abort.
                if (xfer_cnt != {DATA_W{1'b1}}) xfer_nxt = xfer_cnt + DATA_W'(1);
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (done) begin
                    state_nxt = ST_FINISH;
                end else if (xfer_cnt == cnt_q) begin
                    state_nxt = ST_ERROR;
                end else begin
                    state_nxt = ST_REQ;
                    tmo_nxt   = '0;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        if (abort && (state inside {ST_WR_CTRL, ST_LD_ADDR, ST_LD_WCNT, ST_ENABLE,
                                    ST_REQ, ST_STEP, ST_CHECK})) begin
            state_nxt = ST_ERROR;
        end

        // WR_CTRL is only entered from the start cycle, so the live ctrl_word is the captured one.
        case (state_nxt)
            ST_WR_CTRL: begin
                instr_nxt  = INS_WR_CTRL;
                datain_nxt = ctrl_word;
            end
            ST_LD_ADDR: begin
                instr_nxt  = INS_LD_ADDR;
                datain_nxt = base_q;
            end
            ST_LD_WCNT: begin
                instr_nxt  = INS_LD_WCNT;
                datain_nxt = cnt_q;
            end
            ST_ENABLE: instr_nxt = INS_ENABLE;
            ST_REQ: begin
                instr_nxt = INS_ENABLE;
                req_nxt   = 1'b1;
            end
            ST_STEP: step_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmo      <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            xfer_cnt <= '0;
            instr    <= IDLE_INSTR;
            datain   <= '0;
            cina     <= 1'b0;
            cinw     <= 1'b0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            blk_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmo      <= tmo_nxt;
            xfer_cnt <= xfer_nxt;
            if (capture) begin
                base_q <= base_addr;
                cnt_q  <= word_cnt;
            end
            instr    <= instr_nxt;
            datain   <= datain_nxt;
            cina     <= step_nxt;
            cinw     <= step_nxt;
            mem_req  <= req_nxt;
            busy     <= (state_nxt != ST_IDLE);
            blk_done <= (state_nxt == ST_FINISH);
            err      <= (state_nxt == ST_ERROR);
        end
    end

    // Address is only presented to memory while a transfer is being requested.
    assign mem_addr = mem_req ? address : '0;

endmodule
